// File: rtl/branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : branch_sequencer
// Description : Next-PC sequencer. Runs the fetch/execute handshake and holds
//               a small hardware return-address stack.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_sequencer #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                clock,
    input  logic                nReset,
    output logic                imem_req,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic                ctrl_valid,
    output logic                ctrl_ready,
    input  logic                br_en,
    input  logic                br_sense,
    input  logic                cmp_result,
    input  logic [PC_WIDTH-1:0] br_target,
    input  logic                call,
    input  logic                ret,
    input  logic                halt,
    output logic [PC_WIDTH-1:0] pc,
    output logic                halted,
    output logic                stack_err
);

    localparam int c_IDX_W = $clog2(STACK_DEPTH);
    localparam int c_SP_W  = c_IDX_W + 1;
    localparam logic [c_SP_W-1:0] c_SP_FULL = c_SP_W'(STACK_DEPTH);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } state_t;

    state_t              r_state;
    logic [PC_WIDTH-1:0] r_pc;
    logic [c_SP_W-1:0]   r_sp;
    logic                r_stack_err;
    logic [PC_WIDTH-1:0] r_stack [STACK_DEPTH];

    logic                w_transfer;
    logic                w_empty;
    logic                w_full;
    logic                w_taken;
    logic                w_push;
    logic [PC_WIDTH-1:0] w_pc_inc;
    logic [c_SP_W-1:0]   w_sp_dec;
    logic [c_IDX_W-1:0]  w_push_idx;
    logic [c_IDX_W-1:0]  w_top_idx;

    assign w_transfer = (r_state == S_EXEC) && ctrl_valid;
    assign w_empty    = (r_sp == '0);
    assign w_full     = (r_sp == c_SP_FULL);
    assign w_taken    = br_en && (cmp_result == br_sense);
    assign w_pc_inc   = r_pc + PC_WIDTH'(1);
    assign w_sp_dec   = r_sp - c_SP_W'(1);
    assign w_push_idx = r_sp[c_IDX_W-1:0];
    assign w_top_idx  = w_sp_dec[c_IDX_W-1:0];
    // Push only when the call actually wins priority and there is room.
    assign w_push     = w_transfer && !halt && !ret && call && !w_full;

    always_ff @(posedge clock or negedge nReset) begin
        if (!nReset) begin
            r_state     <= S_FETCH;
            r_pc        <= '0;
            r_sp        <= '0;
            r_stack_err <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (ctrl_valid) begin
                        r_state <= S_FETCH;
                        if (halt) begin
                            r_state <= S_HALT;
                        end else if (ret) begin
                            if (w_empty) begin
                                r_pc        <= w_pc_inc;
                                r_stack_err <= 1'b1;
                            end else begin
                                r_pc <= r_stack[w_top_idx];
                                r_sp <= w_sp_dec;
                            end
                        end else if (call) begin
                            r_pc <= br_target;
                            if (w_full) begin
                                r_stack_err <= 1'b1;
                            end else begin
                                r_sp <= r_sp + c_SP_W'(1);
                            end
                        end else if (w_taken) begin
                            r_pc <= br_target;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                S_HALT: begin
                    r_state <= S_HALT;
                end
                default: begin
                    r_state <= S_HALT;
                end
            endcase
        end
    end

    // Stack storage carries no reset; only entries below the pointer are read.
    always_ff @(posedge clock) begin
        if (w_push) begin
            r_stack[w_push_idx] <= w_pc_inc;
        end
    end

    assign imem_req   = (r_state == S_FETCH);
    assign imem_addr  = r_pc;
    assign ctrl_ready = (r_state == S_EXEC);
    assign halted     = (r_state == S_HALT);
    assign pc         = r_pc;
    assign stack_err  = r_stack_err;

endmodule
`default_nettype wire

// File: tb/tb_branch_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_sequencer
// Description : Directed self-checking bench for branch_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_sequencer;

    logic       clock = 1'b0;
    logic       nReset = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack = 1'b0;
    logic       ctrl_valid = 1'b0;
    logic       ctrl_ready;
    logic       br_en = 1'b0;
    logic       br_sense = 1'b0;
    logic       cmp_result = 1'b0;
    logic [7:0] br_target = 8'h00;
    logic       call = 1'b0;
    logic       ret = 1'b0;
    logic       halt = 1'b0;
    logic [7:0] pc;
    logic       halted;
    logic       stack_err;

    int errors = 0;
    int checks = 0;

    branch_sequencer #(.PC_WIDTH(8), .STACK_DEPTH(4)) dut (
        .clock(clock), .nReset(nReset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .br_en(br_en), .br_sense(br_sense), .cmp_result(cmp_result),
        .br_target(br_target), .call(call), .ret(ret), .halt(halt),
        .pc(pc), .halted(halted), .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    // Waits (bounded) for a fetch request, returns its address and acks it.
    // A missing request yields X so the caller's comparison fails.
    task automatic do_fetch(output logic [7:0] addr);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        addr = (imem_req === 1'b1) ? imem_addr : 8'hxx;
        imem_ack = 1'b1;
        @(posedge clock); #1;
        imem_ack = 1'b0;
    endtask

    task automatic do_exec(input logic h, input logic r, input logic c, input logic be,
                           input logic bs, input logic cr, input logic [7:0] tgt);
        halt = h; ret = r; call = c; br_en = be; br_sense = bs; cmp_result = cr;
        br_target = tgt; ctrl_valid = 1'b1;
        @(posedge clock); #1;
        ctrl_valid = 1'b0; halt = 1'b0; ret = 1'b0; call = 1'b0; br_en = 1'b0;
        br_sense = 1'b0; cmp_result = 1'b0; br_target = 8'h00;
    endtask

    task automatic sync_reset_pulse();
        nReset = 1'b0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        nReset = 1'b1;
    endtask

    task automatic test_reset();
        sync_reset_pulse();
        checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h expected 00", pc); end
        checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL reset_req: got %b expected 1", imem_req); end
        checks++; if (imem_addr !== 8'h00) begin errors++; $display("FAIL reset_addr: got %h expected 00", imem_addr); end
        checks++; if (ctrl_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", ctrl_ready); end
        checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", stack_err); end
    endtask

    task automatic test_sequential();
        logic [7:0] a;
        do_fetch(a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL seq_addr0: got %h expected 00", a); end
        checks++; if (ctrl_ready !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("FAIL seq_exec_hs: got ready=%b req=%b expected ready=1 req=0", ctrl_ready, imem_req); end
        @(posedge clock); #1;
        checks++; if (ctrl_ready !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL seq_exec_hold: got ready=%b pc=%h expected ready=1 pc=00", ctrl_ready, pc); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        checks++; if (imem_req !== 1'b1 || ctrl_ready !== 1'b0) begin errors++; $display("FAIL seq_two_cycle: got req=%b ready=%b expected req=1 ready=0", imem_req, ctrl_ready); end
        // A control word offered during FETCH must not be consumed.
        halt = 1'b1; ctrl_valid = 1'b1;
        @(posedge clock); #1;
        halt = 1'b0; ctrl_valid = 1'b0;
        checks++; if (pc !== 8'h01 || halted !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL seq_valid_in_fetch: got pc=%h halted=%b req=%b expected pc=01 halted=0 req=1", pc, halted, imem_req); end
        do_fetch(a);
        checks++; if (a !== 8'h01) begin errors++; $display("FAIL seq_addr1: got %h expected 01", a); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h02) begin errors++; $display("FAIL seq_addr2: got %h expected 02", a); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h03) begin errors++; $display("FAIL seq_addr3: got %h expected 03", a); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
    endtask

    task automatic test_branch();
        logic [7:0] a;
        do_fetch(a);
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h05) begin errors++; $display("FAIL br_start: got %h expected 05", a); end
        do_exec(0, 0, 0, 1, 1, 1, 8'h40);
        do_fetch(a);
        checks++; if (a !== 8'h40) begin errors++; $display("FAIL br_taken_s1: got %h expected 40", a); end
        do_exec(0, 0, 0, 1, 1, 1, 8'h05);
        do_fetch(a);
        do_exec(0, 0, 0, 1, 1, 0, 8'h40);
        do_fetch(a);
        checks++; if (a !== 8'h06) begin errors++; $display("FAIL br_not_taken: got %h expected 06", a); end
        do_exec(0, 0, 0, 1, 1, 1, 8'h05);
        do_fetch(a);
        do_exec(0, 0, 0, 1, 0, 0, 8'h40);
        do_fetch(a);
        checks++; if (a !== 8'h40) begin errors++; $display("FAIL br_taken_s0: got %h expected 40", a); end
        do_exec(0, 0, 0, 1, 0, 0, 8'h10);
    endtask

    task automatic test_call_ret();
        logic [7:0] a;
        do_fetch(a);
        checks++; if (a !== 8'h10) begin errors++; $display("FAIL cr_start: got %h expected 10", a); end
        do_exec(0, 0, 1, 0, 0, 0, 8'h80);
        do_fetch(a);
        checks++; if (a !== 8'h80) begin errors++; $display("FAIL cr_call: got %h expected 80", a); end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL cr_err_clear: got %b expected 0", stack_err); end
        do_exec(0, 1, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h11) begin errors++; $display("FAIL cr_ret: got %h expected 11", a); end
        do_exec(0, 1, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h12) begin errors++; $display("FAIL cr_underflow_pc: got %h expected 12", a); end
        checks++; if (stack_err !== 1'b1) begin errors++; $display("FAIL cr_underflow_err: got %b expected 1", stack_err); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h13 || stack_err !== 1'b1) begin errors++; $display("FAIL cr_err_sticky: got pc=%h err=%b expected pc=13 err=1", a, stack_err); end
    endtask

    task automatic test_nested();
        logic [7:0] a;
        logic [7:0] tg [5];
        logic [7:0] rv [4];
        tg[0] = 8'h20; tg[1] = 8'h30; tg[2] = 8'h40; tg[3] = 8'h50; tg[4] = 8'h60;
        rv[0] = 8'h41; rv[1] = 8'h31; rv[2] = 8'h21; rv[3] = 8'h01;
        sync_reset_pulse();
        do_fetch(a);
        for (int i = 0; i < 4; i++) begin
            do_exec(0, 0, 1, 0, 0, 0, tg[i]);
            do_fetch(a);
            checks++; if (a !== tg[i]) begin errors++; $display("FAIL nest_call%0d: got %h expected %h", i, a, tg[i]); end
        end
        checks++; if (stack_err !== 1'b0) begin errors++; $display("FAIL nest_full_no_err: got %b expected 0", stack_err); end
        do_exec(0, 0, 1, 0, 0, 0, tg[4]);
        do_fetch(a);
        checks++; if (a !== 8'h60 || stack_err !== 1'b1) begin errors++; $display("FAIL nest_overflow: got pc=%h err=%b expected pc=60 err=1", a, stack_err); end
        for (int i = 0; i < 4; i++) begin
            do_exec(0, 1, 0, 0, 0, 0, 8'h00);
            do_fetch(a);
            checks++; if (a !== rv[i]) begin errors++; $display("FAIL nest_ret%0d: got %h expected %h", i, a, rv[i]); end
        end
    endtask

    task automatic test_wrap_halt();
        logic [7:0] a;
        do_exec(0, 0, 0, 1, 1, 1, 8'hFF);
        do_fetch(a);
        checks++; if (a !== 8'hFF) begin errors++; $display("FAIL wrap_start: got %h expected ff", a); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL wrap_pc: got %h expected 00", a); end
        do_exec(1, 0, 1, 1, 1, 1, 8'h55);
        checks++; if (halted !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL halt_enter: got halted=%b pc=%h expected halted=1 pc=00", halted, pc); end
        checks++; if (imem_req !== 1'b0 || ctrl_ready !== 1'b0) begin errors++; $display("FAIL halt_outputs: got req=%b ready=%b expected req=0 ready=0", imem_req, ctrl_ready); end
        imem_ack = 1'b1; ctrl_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            checks++; if (imem_req !== 1'b0 || halted !== 1'b1 || pc !== 8'h00) begin errors++; $display("FAIL halt_stays%0d: got req=%b halted=%b pc=%h expected req=0 halted=1 pc=00", i, imem_req, halted, pc); end
        end
        imem_ack = 1'b0; ctrl_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [7:0] a;
        sync_reset_pulse();
        do_fetch(a);
        do_exec(0, 1, 0, 0, 0, 0, 8'h00);
        @(posedge clock); #1;
        checks++; if (stack_err !== 1'b1 || pc !== 8'h01) begin errors++; $display("FAIL ar_setup: got err=%b pc=%h expected err=1 pc=01", stack_err, pc); end
        #2 nReset = 1'b0;
        #1;
        checks++; if (pc !== 8'h00 || halted !== 1'b0 || stack_err !== 1'b0 || imem_req !== 1'b1) begin errors++; $display("FAIL ar_fetch: got pc=%h halted=%b err=%b req=%b expected 00 0 0 1", pc, halted, stack_err, imem_req); end
        #1 nReset = 1'b1;
        @(posedge clock); #1;
        do_fetch(a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL ar_refetch: got %h expected 00", a); end
        do_exec(0, 0, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        do_exec(0, 1, 0, 0, 0, 0, 8'h00);
        do_fetch(a);
        do_exec(1, 0, 0, 0, 0, 0, 8'h00);
        checks++; if (halted !== 1'b1 || pc !== 8'h02 || stack_err !== 1'b1) begin errors++; $display("FAIL ar_halt_setup: got halted=%b pc=%h err=%b expected 1 02 1", halted, pc, stack_err); end
        #2 nReset = 1'b0;
        #1;
        checks++; if (pc !== 8'h00 || halted !== 1'b0 || stack_err !== 1'b0) begin errors++; $display("FAIL ar_halt: got pc=%h halted=%b err=%b expected 00 0 0", pc, halted, stack_err); end
        #1 nReset = 1'b1;
        @(posedge clock); #1;
        do_fetch(a);
        checks++; if (a !== 8'h00) begin errors++; $display("FAIL ar_halt_refetch: got %h expected 00", a); end
    endtask

    initial begin
        @(posedge clock); #1;
        test_reset();
        test_sequential();
        test_branch();
        test_call_ret();
        test_nested();
        test_wrap_halt();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
